fetch_sequencer: RTL

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Purpose  : Instruction fetch sequencer. Reads one 16-bit word at a time
//            from an instruction ROM using a req/ack handshake, then offers
//            it to a consumer using a valid/ready handshake. Supports
//            run/halt control and pc redirects (jumps).
// Ports    : clk                   - sole clock, rising edge
//            reset                 - synchronous reset, active low
//            run, halt             - start/resume and stop-after-issue control
//            jump_valid, jump_addr - pc redirect
//            rom_req, rom_addr     - ROM read request; address is always pc
//            rom_ack, rom_data     - ROM read response
//            instr_valid, instr, instr_pc, instr_ready - consumer handshake
//            pc, state, issued     - status: program counter, FSM state,
//                                    count of completed handshakes
// Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        halt,
    input  logic        jump_valid,
    input  logic [15:0] jump_addr,
    output logic        rom_req,
    output logic [15:0] rom_addr,
    input  logic        rom_ack,
    input  logic [15:0] rom_data,
    output logic        instr_valid,
    output logic [15:0] instr,
    output logic [15:0] instr_pc,
    input  logic        instr_ready,
    output logic [15:0] pc,
    output logic [1:0]  state,
    output logic [15:0] issued
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_FETCH  = 2'b01,
        ST_ISSUE  = 2'b10,
        ST_HALTED = 2'b11
    } state_t;

    state_t      r_state;
    logic [15:0] r_pc;
    logic [15:0] r_instr;
    logic [15:0] r_instr_pc;
    logic [15:0] r_issued;

    state_t      w_state_next;
    logic [15:0] w_pc_next;
    logic [15:0] w_instr_next;
    logic [15:0] w_instr_pc_next;
    logic [15:0] w_issued_next;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_pc       <= 16'h0000;
            r_instr    <= 16'h0000;
            r_instr_pc <= 16'h0000;
            r_issued   <= 16'h0000;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_instr    <= w_instr_next;
            r_instr_pc <= w_instr_pc_next;
            r_issued   <= w_issued_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath update logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next    = r_state;
        w_pc_next       = r_pc;
        w_instr_next    = r_instr;
        w_instr_pc_next = r_instr_pc;
        w_issued_next   = r_issued;

        case (r_state)
            ST_IDLE, ST_HALTED: begin
                if (run && !halt) begin
                    w_state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // A jump discards any ROM response arriving the same cycle;
                // the fetch restarts from the new pc next cycle.
                if (!jump_valid && rom_ack) begin
                    w_instr_next    = rom_data;
                    w_instr_pc_next = r_pc;
                    w_pc_next       = r_pc + 16'd1;
                    w_state_next    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // A completed handshake always counts, even alongside a
                // jump; only an unaccepted offer is flushed by a jump.
                if (instr_ready) begin
                    w_issued_next = r_issued + 16'd1;
                    w_state_next  = halt ? ST_HALTED : ST_FETCH;
                end else if (jump_valid) begin
                    w_state_next = ST_FETCH;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // Redirect overrides the increment in every state.
        if (jump_valid) begin
            w_pc_next = jump_addr;
        end
    end

    // ------------------------------------------------------------------
    // Moore outputs
    // ------------------------------------------------------------------
    assign rom_req     = (r_state == ST_FETCH);
    assign instr_valid = (r_state == ST_ISSUE);
    assign rom_addr    = r_pc;
    assign pc          = r_pc;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign issued      = r_issued;
    assign state       = r_state;

endmodule
`default_nettype wire
